// File: rtl/lsu_mem_if.sv
// lsu_mem_if: load/store unit between the core execute stage and data memory.
// Accepts one request at a time, steers bytes onto memory lanes, generates byte
// enables, extends load data, rejects misaligned/illegal-size requests without
// touching memory, and stalls the core while memory inserts wait states.
// Optional feature: define LSU_TIMEOUT_EN to fault a request whose memory
// transaction stays unanswered for TIMEOUT BUSY cycles.
module lsu_mem_if #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              stall,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_fault,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_reg;
    logic [OFFW-1:0]   off_reg;
    logic [1:0]        size_reg;
    logic              uns_reg;

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]     wait_cnt_reg;
`endif

    // Lanes covered by an access of 2^sz bytes starting at lane 0.
    function automatic logic [NB-1:0] size_lanes(input logic [1:0] sz);
        logic [NB-1:0] lanes;
        lanes = '0;
        for (int i = 0; i < NB; i++) begin
            lanes[i] = (i < (1 << sz));
        end
        return lanes;
    endfunction

    logic              accept;
    logic              illegal;
    logic [2:0]        align_mask;
    logic [OFFW-1:0]   req_off;
    logic [NB-1:0]     load_lanes;
    logic [XLEN-1:0]   load_mask;
    logic [XLEN-1:0]   rd_shift;
    logic              load_sign;
    logic [XLEN-1:0]   load_ext;

    assign req_ready = (state_reg == IDLE);
    assign stall     = ((state_reg == IDLE) && req_valid) || (state_reg == BUSY);
    assign accept    = req_valid && req_ready;
    assign req_off   = req_addr[OFFW-1:0];

    // Request legality: address must be a multiple of the access size, and a
    // double access only exists on a 64-bit datapath.
    always_comb begin
        align_mask = 3'b000;
        case (req_size)
            2'b00:   align_mask = 3'b000;
            2'b01:   align_mask = 3'b001;
            2'b10:   align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
        illegal = (|(req_addr[2:0] & align_mask)) ||
                  ((req_size == 2'b11) && (XLEN == 32));
    end

    // Expand the latched access size into a per-bit load mask.
    assign load_lanes = size_lanes(size_reg);
    for (genvar gi = 0; gi < NB; gi++) begin : g_load_mask
        assign load_mask[8*gi +: 8] = {8{load_lanes[gi]}};
    end

    assign rd_shift = mem_rdata >> {off_reg, 3'b000};

    // Sign bit of the truncated load value; a full-width access never extends
    // because its mask covers every bit.
    always_comb begin
        load_sign = 1'b0;
        case (size_reg)
            2'b00:   load_sign = rd_shift[7];
            2'b01:   load_sign = rd_shift[15];
            2'b10:   load_sign = rd_shift[31];
            default: load_sign = rd_shift[XLEN-1];
        endcase
        load_ext = (rd_shift & load_mask) |
                   ((load_sign && !uns_reg) ? ~load_mask : '0);
    end

    // Main control FSM with registered memory-side and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            off_reg      <= '0;
            size_reg     <= '0;
            uns_reg      <= 1'b0;
            mem_valid    <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_be       <= '0;
            mem_wdata    <= '0;
            rsp_valid    <= 1'b0;
            rsp_fault    <= 1'b0;
            rsp_rdata    <= '0;
`ifdef LSU_TIMEOUT_EN
            wait_cnt_reg <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        off_reg  <= req_off;
                        size_reg <= req_size;
                        uns_reg  <= req_unsigned;
                        if (illegal) begin
                            // Rejected without a memory transaction.
                            rsp_valid <= 1'b1;
                            rsp_fault <= 1'b1;
                            rsp_rdata <= '0;
                            state_reg <= RESP;
                        end else begin
                            mem_valid <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                            mem_be    <= size_lanes(req_size) << req_off;
                            mem_wdata <= req_wdata << {req_off, 3'b000};
`ifdef LSU_TIMEOUT_EN
                            wait_cnt_reg <= '0;
`endif
                            state_reg <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_fault <= 1'b0;
                        rsp_rdata <= mem_we ? '0 : load_ext;
                        state_reg <= RESP;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (wait_cnt_reg == CW'(TIMEOUT - 1)) begin
                        // This cycle's miss brings the count to TIMEOUT.
                        mem_valid <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_fault <= 1'b1;
                        rsp_rdata <= '0;
                        state_reg <= RESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
`endif
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_fault <= 1'b0;
                    rsp_rdata <= '0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Self-checking bench for lsu_mem_if (XLEN=32): directed steps from the test
// plan followed by randomized requests checked against a byte-arithmetic model.
module tb_lsu_mem_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int vectors    = 0;
    int miscompares = 0;

    lsu_mem_if #(.XLEN(32), .TIMEOUT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_fault    (rsp_fault),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain byte arithmetic on a 4-byte memory word.
    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata,
                         output logic legal, output logic [31:0] e_addr,
                         output logic [3:0] e_be, output logic [31:0] e_wdata,
                         output logic [31:0] e_rdata);
        longint unsigned nbytes, off, v, w, lim;
        nbytes  = 64'd1 << size;
        off     = 64'(addr % 4);
        legal   = (size != 2'b11) && ((addr % 32'(nbytes)) == 0);
        e_addr  = addr - 32'(off);
        e_be    = 4'(((64'd1 << nbytes) - 1) << off);
        w       = 64'(wdata) * (64'd1 << (8 * off));
        e_wdata = w[31:0];
        lim     = 64'd1 << (8 * nbytes);
        v       = (64'(rdata) / (64'd1 << (8 * off))) % lim;
        if (!uns && v >= lim / 2) v = v - lim;
        e_rdata = we ? 32'd0 : v[31:0];
    endtask

    // One complete request: issue, check memory side, insert waits, check response.
    task automatic do_txn(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int waits);
        logic        legal;
        logic [31:0] e_addr, e_wdata, e_rdata;
        logic [3:0]  e_be;
        model(we, size, uns, addr, wdata, rdata, legal, e_addr, e_be, e_wdata, e_rdata);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        #1;
        chk({tag, " idle_stall"}, 64'(stall), 64'd1);
        chk({tag, " idle_ready"}, 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        // Scramble the request after acceptance; the LSU must have latched it.
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom); req_unsigned = 1'($urandom); req_we = 1'($urandom);
        #1;
        if (!legal) begin
            chk({tag, " flt_mem_valid"}, 64'(mem_valid), 64'd0);
            chk({tag, " flt_rsp_valid"}, 64'(rsp_valid), 64'd1);
            chk({tag, " flt_rsp_fault"}, 64'(rsp_fault), 64'd1);
            chk({tag, " flt_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
            @(posedge clk); #2;
            chk({tag, " flt_rsp_end"}, 64'(rsp_valid), 64'd0);
            chk({tag, " flt_ready"}, 64'(req_ready), 64'd1);
            return;
        end
        chk({tag, " mem_valid"}, 64'(mem_valid), 64'd1);
        chk({tag, " mem_we"}, 64'(mem_we), 64'(we));
        chk({tag, " mem_addr"}, 64'(mem_addr), 64'(e_addr));
        chk({tag, " mem_be"}, 64'(mem_be), 64'(e_be));
        if (we) chk({tag, " mem_wdata"}, 64'(mem_wdata), 64'(e_wdata));
        for (int i = 0; i < waits; i++) begin
            mem_ready = 1'b0; mem_rdata = $urandom;
            @(posedge clk); #2;
            chk({tag, " wait_mem_valid"}, 64'(mem_valid), 64'd1);
            chk({tag, " wait_mem_addr"}, 64'(mem_addr), 64'(e_addr));
            chk({tag, " wait_mem_be"}, 64'(mem_be), 64'(e_be));
            if (we) chk({tag, " wait_mem_wdata"}, 64'(mem_wdata), 64'(e_wdata));
            chk({tag, " wait_stall"}, 64'(stall), 64'd1);
            chk({tag, " wait_ready"}, 64'(req_ready), 64'd0);
            chk({tag, " wait_rsp"}, 64'(rsp_valid), 64'd0);
        end
        mem_ready = 1'b1; mem_rdata = rdata;
        @(posedge clk); #1;
        mem_ready = 1'b0; mem_rdata = $urandom;
        #1;
        chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, " rsp_fault"}, 64'(rsp_fault), 64'd0);
        chk({tag, " rsp_rdata"}, 64'(rsp_rdata), 64'(e_rdata));
        chk({tag, " rsp_mem_valid"}, 64'(mem_valid), 64'd0);
        chk({tag, " rsp_ready"}, 64'(req_ready), 64'd0);
        @(posedge clk); #2;
        chk({tag, " rsp_end"}, 64'(rsp_valid), 64'd0);
        chk({tag, " back_ready"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        logic [1:0]  r_size;
        logic [31:0] r_addr;

        // Reset state.
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        #1;
        chk("rst req_ready", 64'(req_ready), 64'd1);
        chk("rst stall", 64'(stall), 64'd0);
        chk("rst mem_valid", 64'(mem_valid), 64'd0);
        chk("rst mem_be", 64'(mem_be), 64'd0);
        chk("rst mem_addr", 64'(mem_addr), 64'd0);
        chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst rsp_fault", 64'(rsp_fault), 64'd0);
        req_valid = 1'b1; #1;
        chk("rst stall_follows", 64'(stall), 64'd1);
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #2;

        // mem_ready is ignored while idle.
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(posedge clk); #2;
        chk("idle_ignore rsp_valid", 64'(rsp_valid), 64'd0);
        chk("idle_ignore ready", 64'(req_ready), 64'd1);
        mem_ready = 1'b0;

        // Directed steps.
        do_txn("sb_103",   1'b1, 2'b00, 1'b0, 32'h103, 32'h000000AB, 32'h0, 0);
        do_txn("lh_s",     1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 32'h80011234, 0);
        do_txn("lh_u",     1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 32'h80011234, 0);
        do_txn("lw_200",   1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h80011234, 0);
        do_txn("lb_s",     1'b0, 2'b00, 1'b0, 32'h401, 32'h0, 32'h00008000, 1);
        do_txn("sh_2",     1'b1, 2'b01, 1'b0, 32'h502, 32'h0000CAFE, 32'h0, 0);
        do_txn("mis_w",    1'b0, 2'b10, 1'b0, 32'h106, 32'h0, 32'h0, 0);
        do_txn("mis_h",    1'b1, 2'b01, 1'b0, 32'h107, 32'h12345678, 32'h0, 0);
        do_txn("size11",   1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 0);
        do_txn("wait3",    1'b0, 2'b10, 1'b1, 32'h604, 32'h0, 32'h13579BDF, 3);

`ifdef LSU_TIMEOUT_EN
        // Timeout: mem_valid held for exactly 15 BUSY cycles, then a fault.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h700;
        mem_ready = 1'b0;
        @(posedge clk); #1 req_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1;
            chk("tmo mem_valid", 64'(mem_valid), 64'd1);
            @(posedge clk); #1;
        end
        #1;
        chk("tmo mem_valid_drop", 64'(mem_valid), 64'd0);
        chk("tmo rsp_valid", 64'(rsp_valid), 64'd1);
        chk("tmo rsp_fault", 64'(rsp_fault), 64'd1);
        chk("tmo rsp_rdata", 64'(rsp_rdata), 64'd0);
        @(posedge clk); #2;
        chk("tmo ready", 64'(req_ready), 64'd1);
`else
        // No timeout: the LSU keeps waiting for memory for 100 cycles.
        do_txn("wait100",  1'b1, 2'b10, 1'b0, 32'h800, 32'hA5A5F00D, 32'h0, 100);
`endif

        // Reset in the second BUSY cycle aborts the request asynchronously.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h300;
        mem_ready = 1'b0;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #2;
        chk("abort busy2", 64'(mem_valid), 64'd1);
        rst = 1'b1; #1;
        chk("abort mem_valid", 64'(mem_valid), 64'd0);
        chk("abort stall", 64'(stall), 64'd0);
        chk("abort ready", 64'(req_ready), 64'd1);
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #2;
        chk("abort no_rsp", 64'(rsp_valid), 64'd0);
        do_txn("post_rst", 1'b0, 2'b01, 1'b1, 32'h30E, 32'h0, 32'hF00DBEEF, 1);

        // Randomized requests.
        for (int n = 0; n < 40; n++) begin
            r_size = 2'($urandom_range(0, 3));
            r_addr = $urandom;
            if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~((32'd1 << r_size) - 32'd1);
            do_txn($sformatf("rnd%0d", n), 1'($urandom), r_size, 1'($urandom),
                   r_addr, $urandom, $urandom, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
